// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared register offsets, CTRL bit indices and FSM encodings for the UART TX core
package uart_pkg;

    localparam logic [4:0] REG_TXDATA = 5'h00;
    localparam logic [4:0] REG_STATUS = 5'h04;
    localparam logic [4:0] REG_CTRL   = 5'h08;
    localparam logic [4:0] REG_BAUD   = 5'h0C;

    localparam int CTRL_TX_EN    = 0;
    localparam int CTRL_PAR_EN   = 1;
    localparam int CTRL_PAR_ODD  = 2;
    localparam int CTRL_TWO_STOP = 3;
    localparam int CTRL_IRQ_EN   = 4;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    typedef enum logic [1:0] {
        BUS_IDLE,
        BUS_RESP,
        BUS_DONE
    } bus_state_e;

    // A programmed divisor of zero is treated as one cycle per bit.
    function automatic logic [15:0] eff_div(input logic [15:0] d);
        return (d == 16'd0) ? 16'd1 : d;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - synchronous byte FIFO with push/pop, full/empty flags and occupancy count
// Ports: clk_i/rst_n_i clock and async active-low reset; push_i/wdata_i write side;
//        pop_i/rdata_o read side (rdata_o shows the head entry); full_o, empty_o, count_o status.
module uart_fifo #(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [7:0]    wdata_i,
    output logic [7:0]    rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    // Full/empty come from the registered count, so a push in the same
    // cycle as a pop is still refused when the FIFO was full.
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign rdata_o = mem_q[rptr_q];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/uart_tx_core.sv
// rtl/uart_tx_core.sv - UART register bank, TX FIFO and serialiser behind the APB bridge
// Ports: p_clk/p_rst_n clock and async active-low reset; acc/w_en/r_en/addr/w_data bridge access;
//        ready/r_data/slverr response (valid while ready); tx serial line (idle high); irq.
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] BAUD_RST   = 16'd868
) (
    input  logic        p_clk,
    input  logic        p_rst_n,
    input  logic        acc,
    input  logic        w_en,
    input  logic        r_en,
    input  logic [31:0] addr,
    input  logic [31:0] w_data,
    output logic        ready,
    output logic [31:0] r_data,
    output logic        slverr,
    output logic        tx,
    output logic        irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    bus_state_e    bus_q, bus_d;
    logic [31:0]   r_data_q, r_data_d;
    logic          slverr_q, slverr_d;
    logic [4:0]    ctrl_q, ctrl_d;
    logic [15:0]   baud_q, baud_d;

    tx_state_e     tx_state_q, tx_state_d;
    logic [15:0]   baud_cnt_q, baud_cnt_d;
    logic [15:0]   div_q, div_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          par_en_q, par_en_d;
    logic          par_odd_q, par_odd_d;
    logic          two_stop_q, two_stop_d;
    logic          tx_q, tx_d;
    logic          tx_load;

    logic          fifo_push, fifo_full, fifo_empty;
    logic [7:0]    fifo_rdata;
    logic [CW-1:0] fifo_count;

    logic          acc_go, busy, start_ok, tick;
    logic [31:0]   status;
    logic          unused_ok;

    assign acc_go    = (bus_q == BUS_IDLE) & acc;
    assign busy      = (tx_state_q != TX_IDLE);
    assign start_ok  = ctrl_q[CTRL_TX_EN] & ~fifo_empty;
    assign tick      = (baud_cnt_q == 16'd0);
    assign status    = {24'd0, 4'(fifo_count), 1'b0, fifo_empty, fifo_full, busy};
    assign unused_ok = ^{addr[31:5], w_data[31:16]};

    assign ready  = (bus_q == BUS_RESP);
    assign r_data = r_data_q;
    assign slverr = slverr_q;
    assign tx     = tx_q;
    assign irq    = ctrl_q[CTRL_IRQ_EN] & fifo_empty;

    uart_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (p_clk),
        .rst_n_i (p_rst_n),
        .push_i  (fifo_push),
        .pop_i   (tx_load),
        .wdata_i (w_data[7:0]),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Bus side: decode happens only on the IDLE->RESP transition, and DONE
    // waits for acc to drop, so a held acc cannot repeat a side effect.
    always_comb begin
        bus_d     = bus_q;
        r_data_d  = r_data_q;
        slverr_d  = slverr_q;
        ctrl_d    = ctrl_q;
        baud_d    = baud_q;
        fifo_push = 1'b0;
        case (bus_q)
            BUS_IDLE: if (acc) bus_d = BUS_RESP;
            BUS_RESP: bus_d = BUS_DONE;
            BUS_DONE: if (!acc) bus_d = BUS_IDLE;
            default:  bus_d = BUS_IDLE;
        endcase
        if (acc_go) begin
            r_data_d = '0;
            slverr_d = 1'b0;
            case (addr[4:0])
                REG_TXDATA: begin
                    if (w_en) begin
                        if (fifo_full) slverr_d  = 1'b1;
                        else           fifo_push = 1'b1;
                    end
                end
                REG_STATUS: begin
                    if (w_en)      slverr_d = 1'b1;
                    else if (r_en) r_data_d = status;
                end
                REG_CTRL: begin
                    if (w_en)      ctrl_d   = w_data[4:0];
                    else if (r_en) r_data_d = {27'd0, ctrl_q};
                end
                REG_BAUD: begin
                    if (w_en)      baud_d   = w_data[15:0];
                    else if (r_en) r_data_d = {16'd0, baud_q};
                end
                default: slverr_d = 1'b1;
            endcase
        end
    end

    // TX side: frame parameters are snapshotted on tx_load so register
    // writes during a frame only take effect at the next start bit.
    always_comb begin
        tx_state_d = tx_state_q;
        baud_cnt_d = baud_cnt_q;
        div_d      = div_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        par_en_d   = par_en_q;
        par_odd_d  = par_odd_q;
        two_stop_d = two_stop_q;
        tx_load    = 1'b0;
        case (tx_state_q)
            TX_IDLE: if (start_ok) tx_load = 1'b1;
            TX_START: begin
                if (tick) begin
                    tx_state_d = TX_DATA;
                    bit_d      = 3'd0;
                end
            end
            TX_DATA: begin
                if (tick) begin
                    if (bit_q == 3'd7) begin
                        tx_state_d = par_en_q ? TX_PARITY : TX_STOP;
                        bit_d      = 3'd0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            TX_PARITY: begin
                if (tick) begin
                    tx_state_d = TX_STOP;
                    bit_d      = 3'd0;
                end
            end
            TX_STOP: begin
                // bit_q counts stop bits here; chaining straight into the
                // next start bit keeps queued frames gap-free.
                if (tick) begin
                    if (two_stop_q && bit_q == 3'd0) bit_d = 3'd1;
                    else if (start_ok)               tx_load = 1'b1;
                    else                             tx_state_d = TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
        if (tx_state_q != TX_IDLE) begin
            baud_cnt_d = tick ? (div_q - 16'd1) : (baud_cnt_q - 16'd1);
        end
        if (tx_load) begin
            tx_state_d = TX_START;
            shreg_d    = fifo_rdata;
            par_en_d   = ctrl_q[CTRL_PAR_EN];
            par_odd_d  = ctrl_q[CTRL_PAR_ODD];
            two_stop_d = ctrl_q[CTRL_TWO_STOP];
            div_d      = eff_div(baud_q);
            baud_cnt_d = eff_div(baud_q) - 16'd1;
        end
        // Line level follows the current state one cycle later (registered).
        case (tx_state_q)
            TX_START:  tx_d = 1'b0;
            TX_DATA:   tx_d = shreg_q[bit_q];
            TX_PARITY: tx_d = (^shreg_q) ^ par_odd_q;
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge p_clk or negedge p_rst_n) begin
        if (!p_rst_n) begin
            bus_q      <= BUS_IDLE;
            r_data_q   <= '0;
            slverr_q   <= 1'b0;
            ctrl_q     <= '0;
            baud_q     <= BAUD_RST;
            tx_state_q <= TX_IDLE;
            baud_cnt_q <= '0;
            div_q      <= 16'd1;
            bit_q      <= '0;
            shreg_q    <= '0;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            two_stop_q <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            bus_q      <= bus_d;
            r_data_q   <= r_data_d;
            slverr_q   <= slverr_d;
            ctrl_q     <= ctrl_d;
            baud_q     <= baud_d;
            tx_state_q <= tx_state_d;
            baud_cnt_q <= baud_cnt_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            par_en_q   <= par_en_d;
            par_odd_q  <= par_odd_d;
            two_stop_q <= two_stop_d;
            tx_q       <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_core.sv
// tb/tb_uart_tx_core.sv - self-checking bench for uart_tx_core: register vectors, frame model, corner sequences
module tb_uart_tx_core;

    localparam int HSZ = 65536;

    logic        p_clk   = 1'b0;
    logic        p_rst_n = 1'b0;
    logic        acc     = 1'b0;
    logic        w_en    = 1'b0;
    logic        r_en    = 1'b0;
    logic [31:0] addr    = '0;
    logic [31:0] w_data  = '0;
    logic        ready, slverr, tx, irq;
    logic [31:0] r_data;

    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;
    int   last_e = 0;
    logic tx_hist [HSZ];
    bit   expq [$];

    typedef struct {
        bit          wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rd;
        bit          exp_err;
        bit          chk_rd;
    } vec_t;
    vec_t vecs [18];

    uart_tx_core #(.FIFO_DEPTH(8), .BAUD_RST(16'd868)) dut (
        .p_clk   (p_clk),
        .p_rst_n (p_rst_n),
        .acc     (acc),
        .w_en    (w_en),
        .r_en    (r_en),
        .addr    (addr),
        .w_data  (w_data),
        .ready   (ready),
        .r_data  (r_data),
        .slverr  (slverr),
        .tx      (tx),
        .irq     (irq)
    );

    always #5 p_clk = ~p_clk;
    always @(posedge p_clk) cyc <= cyc + 1;
    always @(negedge p_clk) if (cyc < HSZ) tx_hist[cyc] = tx;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, fails=%0d", fails);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // One bridge access, started and finished on a falling edge.
    task automatic bus(input bit wr, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic err);
        acc = 1'b1; w_en = wr; r_en = !wr; addr = a; w_data = d;
        @(posedge p_clk); @(negedge p_clk);
        last_e = cyc;
        chk("ready_pulse", {31'd0, ready}, 32'd1);
        rd = r_data; err = slverr;
        acc = 1'b0; w_en = 1'b0; r_en = 1'b0;
        @(posedge p_clk); @(negedge p_clk);
        chk("ready_drop", {31'd0, ready}, 32'd0);
        @(posedge p_clk); @(negedge p_clk);
    endtask

    task automatic wr_reg(input logic [31:0] a, input logic [31:0] d, input bit exp_err, input string nm);
        logic [31:0] rd; logic err;
        bus(1'b1, a, d, rd, err);
        chk(nm, {31'd0, err}, {31'd0, exp_err});
    endtask

    task automatic rd_reg(input logic [31:0] a, input logic [31:0] exp, input string nm);
        logic [31:0] rd; logic err;
        bus(1'b0, a, 32'd0, rd, err);
        chk(nm, rd, exp);
    endtask

    function automatic void add_level(bit v, int n);
        for (int i = 0; i < n; i++) expq.push_back(v);
    endfunction

    // Reference frame: start 0, data LSB first, optional parity, 1 or 2 stops.
    function automatic void add_frame(logic [7:0] b, bit pe, bit po, bit ts, int div);
        int d;
        d = (div == 0) ? 1 : div;
        add_level(1'b0, d);
        for (int i = 0; i < 8; i++) add_level(b[i], d);
        if (pe) add_level((^b) ^ po, d);
        add_level(1'b1, d);
        if (ts) add_level(1'b1, d);
    endfunction

    task automatic check_tx(input int from, input string nm);
        int n; int bad; int guard;
        n = expq.size(); bad = -1; guard = 0;
        while (cyc <= from + n && guard < 20000) begin
            @(negedge p_clk);
            guard++;
        end
        checks++;
        if (guard >= 20000) begin
            fails++;
            $display("FAIL %s: timed out waiting for frame window", nm);
        end else begin
            for (int i = 0; i < n; i++)
                if (bad < 0 && tx_hist[from + i] !== expq[i]) bad = i;
            if (bad >= 0) begin
                fails++;
                $display("FAIL %s: tx at offset %0d got %b expected %b", nm, bad, tx_hist[from + bad], expq[bad]);
            end
        end
        expq.delete();
    endtask

    initial begin
        logic [31:0] rd;
        logic        err;
        logic [7:0]  b1, b2;
        bit          pe, po, ts;
        int          dv, t0;

        repeat (3) @(negedge p_clk);
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_rdata", r_data, 32'd0);
        chk("rst_slverr", {31'd0, slverr}, 32'd0);
        p_rst_n = 1'b1;
        @(negedge p_clk);

        vecs[0]  = '{0, 32'h08, 32'h0,         32'h0,    0, 1};
        vecs[1]  = '{0, 32'h0C, 32'h0,         32'd868,  0, 1};
        vecs[2]  = '{0, 32'h04, 32'h0,         32'h04,   0, 1};
        vecs[3]  = '{0, 32'h00, 32'h0,         32'h0,    0, 1};
        vecs[4]  = '{0, 32'h10, 32'h0,         32'h0,    1, 1};
        vecs[5]  = '{1, 32'h04, 32'hFF,        32'h0,    1, 0};
        vecs[6]  = '{0, 32'h01, 32'h0,         32'h0,    1, 1};
        vecs[7]  = '{1, 32'h09, 32'h1F,        32'h0,    1, 0};
        vecs[8]  = '{0, 32'h08, 32'h0,         32'h0,    0, 1};
        vecs[9]  = '{1, 32'h08, 32'hFFFF_FFE0, 32'h0,    0, 0};
        vecs[10] = '{0, 32'h08, 32'h0,         32'h0,    0, 1};
        vecs[11] = '{1, 32'h0C, 32'h0001_2345, 32'h0,    0, 0};
        vecs[12] = '{0, 32'h0C, 32'h0,         32'h2345, 0, 1};
        vecs[13] = '{0, 32'h04, 32'h0,         32'h04,   0, 1};
        vecs[14] = '{1, 32'h08, 32'h1F,        32'h0,    0, 0};
        vecs[15] = '{0, 32'h08, 32'h0,         32'h1F,   0, 1};
        vecs[16] = '{0, 32'h1C, 32'h0,         32'h0,    1, 1};
        vecs[17] = '{1, 32'h02, 32'h55,        32'h0,    1, 0};
        for (int i = 0; i < 18; i++) begin
            bus(vecs[i].wr, vecs[i].a, vecs[i].d, rd, err);
            chk($sformatf("vec%0d_err", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
            if (vecs[i].chk_rd) chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
        end
        chk("irq_on_empty", {31'd0, irq}, 32'd1);
        wr_reg(32'h08, 32'h0, 0, "ctrl_clear");
        chk("irq_off", {31'd0, irq}, 32'd0);

        // Basic frame: BAUD=4, 0xA5, tx falls two edges after the commit.
        wr_reg(32'h0C, 32'd4, 0, "baud4");
        wr_reg(32'h08, 32'h1, 0, "ctrl_en");
        wr_reg(32'h00, 32'hA5, 0, "push_a5");
        t0 = last_e;
        add_level(1'b1, 1); add_frame(8'hA5, 0, 0, 0, 4); add_level(1'b1, 3);
        check_tx(t0 + 1, "frame_a5");

        // Odd parity on 0x03 (parity bit 1), then even parity with two stops.
        wr_reg(32'h0C, 32'd2, 0, "baud2");
        wr_reg(32'h08, 32'h7, 0, "ctrl_odd");
        wr_reg(32'h00, 32'h03, 0, "push_03");
        t0 = last_e;
        add_level(1'b1, 1); add_frame(8'h03, 1, 1, 0, 2); add_level(1'b1, 3);
        check_tx(t0 + 1, "frame_odd_par");
        chk("odd_par_bit", {31'd0, tx_hist[t0 + 2 + 18]}, 32'd1);
        chk("odd_len_22", {31'd0, tx_hist[t0 + 2 + 21]}, 32'd1);
        wr_reg(32'h08, 32'hB, 0, "ctrl_two_stop");
        wr_reg(32'h00, 32'h03, 0, "push_03b");
        t0 = last_e;
        add_level(1'b1, 1); add_frame(8'h03, 1, 0, 1, 2); add_level(1'b1, 3);
        check_tx(t0 + 1, "frame_two_stop");

        // Fill with tx disabled, overflow, then drain back-to-back.
        wr_reg(32'h08, 32'h0, 0, "ctrl_off");
        for (int i = 0; i < 9; i++)
            wr_reg(32'h00, 32'(8'h13 + 8'(i * 29)), (i == 8), $sformatf("fill%0d_err", i));
        rd_reg(32'h04, 32'h82, "status_full");
        chk("tx_idle_while_disabled", {31'd0, tx}, 32'd1);
        add_level(1'b1, 1);
        for (int i = 0; i < 8; i++) add_frame(8'h13 + 8'(i * 29), 0, 0, 0, 2);
        add_level(1'b1, 3);
        wr_reg(32'h08, 32'h1, 0, "ctrl_drain");
        t0 = last_e;
        check_tx(t0 + 1, "burst8");
        rd_reg(32'h04, 32'h04, "status_drained");

        // Clearing tx_en mid-frame: current frame finishes, next stays queued.
        wr_reg(32'h08, 32'h10, 0, "ctrl_irq_only");
        chk("irq_empty", {31'd0, irq}, 32'd1);
        wr_reg(32'h00, 32'h5A, 0, "push_5a");
        chk("irq_nonempty", {31'd0, irq}, 32'd0);
        wr_reg(32'h00, 32'hC3, 0, "push_c3");
        wr_reg(32'h08, 32'h11, 0, "ctrl_go");
        t0 = last_e;
        wr_reg(32'h08, 32'h06, 0, "ctrl_stop_mid");
        add_level(1'b1, 1); add_frame(8'h5A, 0, 0, 0, 2); add_level(1'b1, 8);
        check_tx(t0 + 1, "frame_then_stop");
        rd_reg(32'h04, 32'h10, "status_one_left");
        wr_reg(32'h08, 32'h03, 0, "ctrl_even");
        t0 = last_e;
        add_level(1'b1, 1); add_frame(8'hC3, 1, 0, 0, 2); add_level(1'b1, 3);
        check_tx(t0 + 1, "frame_c3_even");

        // Randomised pairs of queued bytes under random frame settings.
        for (int it = 0; it < 6; it++) begin
            b1 = 8'($urandom); b2 = 8'($urandom);
            pe = 1'($urandom); po = 1'($urandom); ts = 1'($urandom);
            dv = $urandom_range(0, 4);
            wr_reg(32'h0C, 32'(dv), 0, "rnd_baud");
            wr_reg(32'h08, {28'd0, ts, po, pe, 1'b1}, 0, "rnd_ctrl");
            wr_reg(32'h00, {24'd0, b1}, 0, "rnd_push1");
            t0 = last_e;
            wr_reg(32'h00, {24'd0, b2}, 0, "rnd_push2");
            add_level(1'b1, 1); add_frame(b1, pe, po, ts, dv); add_frame(b2, pe, po, ts, dv);
            add_level(1'b1, 3);
            check_tx(t0 + 1, $sformatf("rnd%0d_b%02h_%02h_d%0d", it, b1, b2, dv));
        end

        // Asynchronous reset during a data bit.
        wr_reg(32'h0C, 32'd4, 0, "baud4_rst");
        wr_reg(32'h08, 32'h1, 0, "ctrl_rst");
        wr_reg(32'h00, 32'h00, 0, "push_00");
        t0 = last_e;
        wr_reg(32'h00, 32'h00, 0, "push_00b");
        while (cyc < t0 + 11) @(negedge p_clk);
        chk("tx_low_before_rst", {31'd0, tx}, 32'd0);
        #2 p_rst_n = 1'b0;
        #1 chk("tx_high_async_rst", {31'd0, tx}, 32'd1);
        @(negedge p_clk); @(negedge p_clk);
        p_rst_n = 1'b1;
        @(negedge p_clk);
        rd_reg(32'h04, 32'h04, "status_after_rst");
        rd_reg(32'h0C, 32'd868, "baud_after_rst");
        rd_reg(32'h08, 32'h0, "ctrl_after_rst");
        chk("tx_idle_after_rst", {31'd0, tx}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
